// File: rtl/flappy_pkg.sv
// Shared flappy-bird definitions: game phase encoding, BCD score sizing and BCD increment.
// Latency: none (constants and a combinational helper only).
// Backpressure: not applicable.
`timescale 1ns/1ps
package flappy_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PLAYING = 2'd1;
    localparam logic [1:0] ST_DYING   = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;

    localparam int                 BCD_DIGITS = 4;
    localparam int                 SCORE_W    = 16;
    localparam logic [SCORE_W-1:0] BCD_MAX    = 16'h9999;

    // Ripple +1 through the digits; each 9 wraps to 0 and carries onward.
    function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        logic               carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// 4-digit saturating BCD counter; clr has priority over inc, 9999 holds.
// Latency: count updates one cycle after clr/inc.
// Backpressure: none; every inc is accepted (dropped only when saturated).
`timescale 1ns/1ps
module bcd_counter
    import flappy_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != BCD_MAX)) begin
            count <= bcd_inc(count);
        end
    end

endmodule

// File: rtl/game_controller.sv
// Flappy-bird game sequencer: phase FSM, flap edge detect, death timer, blink, score.
// Latency: Moore outputs and flap_pulse one cycle after the causing event; optional GAME_CONTROLLER_HIGH_SCORE_EN.
// Backpressure: none; inputs are sampled every cycle and never stalled.
`timescale 1ns/1ps
module game_controller
    import flappy_pkg::*;
#(
    parameter int DEATH_FRAMES = 60,
    parameter int BLINK_FRAMES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               flap_btn,
    input  logic               bird_alive,
    input  logic               pipe_passed,
    output logic [1:0]         state,
    output logic               world_reset,
    output logic               world_enable,
    output logic               flap_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               blink
);

    localparam int FC_W = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES + 1) : 1;
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic            btn_q;
    logic            press;
    logic [FC_W-1:0] frame_cnt;
    logic [BC_W-1:0] blink_cnt;
    logic            score_clr;
    logic            score_inc;
    logic            dying_done;

    assign press      = flap_btn & ~btn_q;
    assign score_clr  = (state == ST_IDLE) && press;
    // Death outranks a same-cycle pipe pass, so no point is scored on the fatal cycle.
    assign score_inc  = (state == ST_PLAYING) && bird_alive && pipe_passed;
    assign dying_done = (state == ST_DYING) &&
                        ((frame_cnt == '0) || (frame_tick && (frame_cnt == FC_W'(1))));

    assign world_reset  = (state == ST_IDLE);
    assign world_enable = (state == ST_PLAYING);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            btn_q      <= 1'b1;
            frame_cnt  <= '0;
            blink_cnt  <= '0;
            blink      <= 1'b0;
            flap_pulse <= 1'b0;
        end else begin
            btn_q      <= flap_btn;
            flap_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (press) state <= ST_PLAYING;
                end
                ST_PLAYING: begin
                    if (!bird_alive) begin
                        state     <= ST_DYING;
                        frame_cnt <= FC_W'(DEATH_FRAMES);
                    end else if (press) begin
                        flap_pulse <= 1'b1;
                    end
                end
                ST_DYING: begin
                    if (dying_done) begin
                        state     <= ST_OVER;
                        frame_cnt <= '0;
                        blink     <= 1'b1;
                        blink_cnt <= '0;
                    end else if (frame_tick) begin
                        frame_cnt <= frame_cnt - 1'b1;
                    end
                end
                default: begin
                    if (press) begin
                        state <= ST_IDLE;
                        blink <= 1'b0;
                    end else if (frame_tick) begin
                        if (blink_cnt == BC_W'(BLINK_FRAMES - 1)) begin
                            blink     <= ~blink;
                            blink_cnt <= '0;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    bcd_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .count (score)
    );

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    // Valid BCD orders the same as binary, so a plain magnitude compare is MSD-first.
    always_ff @(posedge clk) begin
        if (!reset) begin
            high_score <= '0;
        end else if (dying_done && (score > high_score)) begin
            high_score <= score;
        end
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with DEATH_FRAMES=4, BLINK_FRAMES=2.
`timescale 1ns/1ps
module tb_game_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        frame_tick;
    logic        flap_btn;
    logic        bird_alive;
    logic        pipe_passed;
    logic [1:0]  state;
    logic        world_reset;
    logic        world_enable;
    logic        flap_pulse;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        blink;

    int total = 0;
    int bad   = 0;

`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
    localparam logic [15:0] HS_EXP = 16'h0025;
`else
    localparam logic [15:0] HS_EXP = 16'h0000;
`endif

    game_controller #(.DEATH_FRAMES(4), .BLINK_FRAMES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_tick   (frame_tick),
        .flap_btn     (flap_btn),
        .bird_alive   (bird_alive),
        .pipe_passed  (pipe_passed),
        .state        (state),
        .world_reset  (world_reset),
        .world_enable (world_enable),
        .flap_pulse   (flap_pulse),
        .score        (score),
        .high_score   (high_score),
        .blink        (blink)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        step();
    endtask

    task automatic pulse_pipe(input int n);
        for (int i = 0; i < n; i++) begin
            pipe_passed = 1'b1;
            step();
            pipe_passed = 1'b0;
            step();
        end
    endtask

    initial begin
        reset = 1'b0; flap_btn = 1'b1; bird_alive = 1'b1;
        frame_tick = 1'b0; pipe_passed = 1'b0;
        step(); step();
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_world_reset", 16'(world_reset), 16'd1);
        chk("rst_world_enable", 16'(world_enable), 16'd0);
        chk("rst_flap_pulse", 16'(flap_pulse), 16'd0);
        chk("rst_blink", 16'(blink), 16'd0);
        chk("rst_score", score, 16'h0000);
        chk("rst_high", high_score, 16'h0000);

        // Button held through reset must not count as a press
        reset = 1'b1;
        step(); step();
        chk("held_no_press", 16'(state), 16'd0);

        // Game 1
        flap_btn = 1'b0; step();
        flap_btn = 1'b1; step();
        chk("g1_playing", 16'(state), 16'd1);
        chk("g1_world_enable", 16'(world_enable), 16'd1);
        chk("g1_world_reset", 16'(world_reset), 16'd0);
        chk("g1_no_flap_from_idle", 16'(flap_pulse), 16'd0);
        step();
        flap_btn = 1'b0; step();
        pulse_pipe(12);
        chk("g1_score12", score, 16'h0012);
        flap_btn = 1'b1; step();
        chk("g1_flap_on", 16'(flap_pulse), 16'd1);
        step();
        chk("g1_flap_one_cycle", 16'(flap_pulse), 16'd0);
        flap_btn = 1'b0; step();
        pulse_pipe(13);
        chk("g1_score25", score, 16'h0025);
        bird_alive = 1'b0; step();
        bird_alive = 1'b1;
        chk("g1_dying", 16'(state), 16'd2);
        chk("g1_dying_enable", 16'(world_enable), 16'd0);
        chk("g1_dying_reset", 16'(world_reset), 16'd0);
        flap_btn = 1'b1; step();
        flap_btn = 1'b0; step();
        chk("g1_dying_press_ignored", 16'(state), 16'd2);
        chk("g1_dying_no_flap", 16'(flap_pulse), 16'd0);
        tick(); tick(); tick();
        chk("g1_dying_after3", 16'(state), 16'd2);
        frame_tick = 1'b1; step();
        frame_tick = 1'b0;
        chk("g1_over", 16'(state), 16'd3);
        chk("g1_blink_start", 16'(blink), 16'd1);
        chk("g1_high", high_score, HS_EXP);
        step();
        tick();
        chk("g1_blink_hold", 16'(blink), 16'd1);
        tick();
        chk("g1_blink_toggle", 16'(blink), 16'd0);
        flap_btn = 1'b1; step();
        chk("g1_back_idle", 16'(state), 16'd0);
        chk("g1_score_persists", score, 16'h0025);
        chk("g1_idle_blink", 16'(blink), 16'd0);
        flap_btn = 1'b0; step();

        // Game 2: lower score must not displace the best
        flap_btn = 1'b1; step();
        chk("g2_playing", 16'(state), 16'd1);
        chk("g2_score_clear", score, 16'h0000);
        flap_btn = 1'b0; step();
        pipe_passed = 1'b1;
        repeat (13) step();
        pipe_passed = 1'b0; step();
        chk("g2_score13", score, 16'h0013);
        bird_alive = 1'b0; step();
        bird_alive = 1'b1;
        tick(); tick(); tick(); tick();
        chk("g2_over", 16'(state), 16'd3);
        chk("g2_high", high_score, HS_EXP);
        flap_btn = 1'b1; step();
        flap_btn = 1'b0; step();
        flap_btn = 1'b1; step();
        flap_btn = 1'b0; step();

        // Game 3: simultaneous death, pipe pass and press; then reset mid-dying
        chk("g3_playing", 16'(state), 16'd1);
        pulse_pipe(5);
        chk("g3_score5", score, 16'h0005);
        bird_alive = 1'b0; pipe_passed = 1'b1; flap_btn = 1'b1;
        step();
        bird_alive = 1'b1; pipe_passed = 1'b0;
        chk("g3_dying", 16'(state), 16'd2);
        chk("g3_no_increment", score, 16'h0005);
        chk("g3_no_flap", 16'(flap_pulse), 16'd0);
        step();
        chk("g3_no_flap_late", 16'(flap_pulse), 16'd0);
        tick();
        reset = 1'b0; step();
        chk("mid_rst_state", 16'(state), 16'd0);
        chk("mid_rst_score", score, 16'h0000);
        chk("mid_rst_blink", 16'(blink), 16'd0);
        chk("mid_rst_high", high_score, 16'h0000);
        chk("mid_rst_world_reset", 16'(world_reset), 16'd1);
        reset = 1'b1; step(); step();
        chk("mid_rst_held_btn", 16'(state), 16'd0);

        // Game 4: saturation
        flap_btn = 1'b0; step();
        flap_btn = 1'b1; step();
        chk("g4_playing", 16'(state), 16'd1);
        flap_btn = 1'b0;
        pipe_passed = 1'b1;
        repeat (9998) step();
        pipe_passed = 1'b0; step();
        chk("g4_score9998", score, 16'h9998);
        pulse_pipe(3);
        chk("g4_saturated", score, 16'h9999);
        bird_alive = 1'b0; step();
        bird_alive = 1'b1;
        tick(); tick(); tick(); tick();
        chk("g4_over", 16'(state), 16'd3);
`ifdef GAME_CONTROLLER_HIGH_SCORE_EN
        chk("g4_high", high_score, 16'h9999);
`else
        chk("g4_high", high_score, 16'h0000);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
